// File: rtl/asynch_toggle_handshake_receiver_if.sv
// Local consumer-side handshake bundle of the toggle CDC receiver.
// The receiver drives the request channel and the response-ready through the
// master modport; the local consumer uses the slave modport.
interface asynch_toggle_handshake_receiver_if #(
  parameter int BW_REQ_DATA  = 4,
  parameter int BW_RESP_DATA = 8
);
  logic                    req_valid;
  logic [BW_REQ_DATA-1:0]  req_data;
  logic                    req_ready;
  logic                    resp_ready;
  logic                    resp_valid;
  logic [BW_RESP_DATA-1:0] resp_data;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/asynch_toggle_handshake_receiver.sv
// Destination half of a two-phase toggle request/response CDC channel.
// The incoming {req_toggle, req_data} bundle is double-flop synchronized; a
// pending request (synchronized toggle differs from the local ack toggle) is
// presented once to the local consumer, its response is captured, and the ack
// toggle is flipped one cycle after the response data is already stable on
// the returned bundle.
module asynch_toggle_handshake_receiver #(
  parameter int BW_REQ_DATA  = 4,
  parameter int BW_RESP_DATA = 8
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic [BW_REQ_DATA:0]    asynch_req_bundle,
  output logic [BW_RESP_DATA:0]   asynch_resp_bundle,
  asynch_toggle_handshake_receiver_if.master local_if,
  output logic                    busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_ACK       = 3'd4
  } state_t;

  logic [BW_REQ_DATA:0]    sync_stage1_r;
  logic [BW_REQ_DATA:0]    sync_stage2_r;
  logic                    sync_tog_s;
  logic [BW_REQ_DATA-1:0]  sync_data_s;
  logic                    pending_s;

  state_t                  state_r;
  state_t                  state_nx_s;
  logic                    load_req_s;
  logic                    load_resp_s;
  logic                    flip_ack_s;

  logic                    ack_tog_r;
  logic [BW_REQ_DATA-1:0]  req_data_r;
  logic [BW_RESP_DATA-1:0] resp_data_r;

  // Two-flop synchronizer for the whole incoming bundle (always enabled).
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      sync_stage1_r <= {(BW_REQ_DATA+1){1'b0}};
      sync_stage2_r <= {(BW_REQ_DATA+1){1'b0}};
    end else begin
      sync_stage1_r <= asynch_req_bundle;
      sync_stage2_r <= sync_stage1_r;
    end
  end

  assign sync_tog_s  = sync_stage2_r[BW_REQ_DATA];
  assign sync_data_s = sync_stage2_r[BW_REQ_DATA-1:0];
  assign pending_s   = sync_tog_s ^ ack_tog_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and register-load decode; SETTLE delays data capture by one
  // cycle so per-bit skew through the synchronizer has resolved.
  always_comb begin
    state_nx_s  = state_r;
    load_req_s  = 1'b0;
    load_resp_s = 1'b0;
    flip_ack_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pending_s) begin
          state_nx_s = ST_SETTLE;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        load_req_s = 1'b1;
        state_nx_s = ST_REQ;
      end
      ST_REQ: begin
        if (local_if.req_ready) begin
          state_nx_s = ST_WAIT_RESP;
        end else begin
          state_nx_s = ST_REQ;
        end
      end
      ST_WAIT_RESP: begin
        if (local_if.resp_valid) begin
          load_resp_s = 1'b1;
          state_nx_s  = ST_ACK;
        end else begin
          state_nx_s  = ST_WAIT_RESP;
        end
      end
      ST_ACK: begin
        flip_ack_s = 1'b1;
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Payload and ack-toggle registers, updated only on the FSM transitions.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      req_data_r  <= {BW_REQ_DATA{1'b0}};
      resp_data_r <= {BW_RESP_DATA{1'b0}};
      ack_tog_r   <= 1'b0;
    end else begin
      if (load_req_s) begin
        req_data_r <= sync_data_s;
      end
      if (load_resp_s) begin
        resp_data_r <= local_if.resp_data;
      end
      if (flip_ack_s) begin
        ack_tog_r <= ~ack_tog_r;
      end
    end
  end

  assign local_if.req_valid  = (state_r == ST_REQ);
  assign local_if.resp_ready = (state_r == ST_WAIT_RESP);
  assign local_if.req_data   = req_data_r;
  assign busy                = (state_r != ST_IDLE);
  assign asynch_resp_bundle  = {ack_tog_r, resp_data_r};

endmodule

// File: tb/tb_asynch_toggle_handshake_receiver.sv
// Scoreboard bench: the source model pushes each issued request payload, the
// consumer model's accepted responses are pushed as the expected return data,
// and independent monitors pop and compare whenever the DUT presents them.
module tb_asynch_toggle_handshake_receiver;

  logic       clk;
  logic       rstnn;
  logic [4:0] asynch_req_bundle;
  logic [8:0] asynch_resp_bundle;
  logic       busy;

  asynch_toggle_handshake_receiver_if #(.BW_REQ_DATA(4), .BW_RESP_DATA(8)) bus ();

  asynch_toggle_handshake_receiver #(.BW_REQ_DATA(4), .BW_RESP_DATA(8)) dut (
    .clk                (clk),
    .rstnn              (rstnn),
    .asynch_req_bundle  (asynch_req_bundle),
    .asynch_resp_bundle (asynch_resp_bundle),
    .local_if           (bus),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_req_q[$];
  logic [7:0] exp_resp_q[$];
  int         n_req = 0;
  logic       src_tog = 1'b0;

  // consumer knobs
  int         rdy_wait = 0;
  int         rsp_wait = 0;
  bit         early_resp = 1'b0;
  logic [7:0] next_resp_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer model: reacts one step after each rising edge.
  initial begin : consumer
    int rdy_cnt;
    int rsp_cnt;
    rdy_cnt = 0;
    rsp_cnt = 0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rstnn) begin
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0; rdy_cnt = 0; rsp_cnt = 0;
      end else if (bus.req_valid) begin
        bus.resp_valid = early_resp;
        if (early_resp) bus.resp_data = 8'hEE;
        if (rdy_cnt < rdy_wait) begin
          bus.req_ready = 1'b0; rdy_cnt++;
        end else begin
          bus.req_ready = 1'b1;
        end
      end else if (bus.resp_ready) begin
        bus.req_ready = 1'b0; rdy_cnt = 0;
        if (rsp_cnt < rsp_wait) begin
          bus.resp_valid = 1'b0; rsp_cnt++;
        end else begin
          bus.resp_valid = 1'b1; bus.resp_data = next_resp_data;
        end
      end else begin
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0; rdy_cnt = 0; rsp_cnt = 0;
      end
    end
  end

  // Request monitor: each handshake must match the oldest issued request.
  initial begin : req_mon
    logic       prev_valid;
    logic       prev_hs;
    logic [3:0] prev_data;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_data = 4'h0;
    forever begin
      @(negedge clk);
      if (rstnn && bus.req_valid) begin
        if (prev_valid && !prev_hs) chk("req_data_stable", bus.req_data, prev_data);
        chk("busy_in_req", busy, 1'b1);
        if (bus.req_ready) begin
          n_req++;
          if (exp_req_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got data %0h with no request outstanding", bus.req_data);
          end else begin
            chk("req_data", bus.req_data, exp_req_q.pop_front());
          end
        end
        prev_valid = 1'b1; prev_hs = bus.req_ready; prev_data = bus.req_data;
      end else begin
        prev_valid = 1'b0; prev_hs = 1'b0;
      end
    end
  end

  // Response-accept monitor: an accepted response is what must come back.
  initial begin : resp_acc_mon
    forever begin
      @(negedge clk);
      if (rstnn && bus.resp_valid && bus.resp_ready) exp_resp_q.push_back(bus.resp_data);
    end
  end

  // Return-bundle monitor: on every ack toggle, data must match and must
  // already have been present one cycle earlier.
  initial begin : bundle_mon
    logic [8:0] prev;
    logic [7:0] e;
    prev = 9'h000;
    forever begin
      @(negedge clk);
      if (rstnn && (asynch_resp_bundle[8] != prev[8])) begin
        if (exp_resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got bundle %0h with no accepted response", asynch_resp_bundle);
        end else begin
          e = exp_resp_q.pop_front();
          chk("resp_data", asynch_resp_bundle[7:0], e);
          chk("resp_before_tog", prev[7:0], e);
        end
      end
      prev = asynch_resp_bundle;
    end
  end

  // Source model: toggle with payload, wait (bounded) for the matching ack.
  task automatic send_req(input logic [3:0] d, input bit chk_lat, input bit skew);
    int lat;
    int tat;
    src_tog = ~src_tog;
    exp_req_q.push_back(d);
    lat = 0; tat = 0;
    if (skew) begin
      asynch_req_bundle = {src_tog, asynch_req_bundle[3:0]};
      @(posedge clk); #1;
    end
    asynch_req_bundle = {src_tog, d};
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (lat == 0 && bus.req_valid) lat = c;
      if (asynch_resp_bundle[8] == src_tog) begin
        tat = c;
        break;
      end
    end
    chk("ack_seen", (tat != 0), 1'b1);
    if (chk_lat) begin
      chk("req_latency", lat, 4);
      chk("turnaround", tat, 7);
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n0;
    int got;
    rstnn = 1'b0;
    asynch_req_bundle = 5'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("idle_req_valid", bus.req_valid, 1'b0);
      chk("idle_resp_ready", bus.resp_ready, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_bundle", asynch_resp_bundle, 9'h000);
    end

    // Basic transaction with tied-high consumer
    next_resp_data = 8'h5C;
    send_req(4'hA, 1'b1, 1'b0);
    chk("basic_bundle", asynch_resp_bundle, {1'b1, 8'h5C});

    // Bring data to 0 for the skew case
    next_resp_data = 8'h11;
    send_req(4'h0, 1'b0, 1'b0);

    // Toggle leads data by one cycle
    next_resp_data = 8'h22;
    send_req(4'h3, 1'b0, 1'b1);

    // Backpressure on both sides, early resp_valid in REQ
    rdy_wait = 10; rsp_wait = 7; early_resp = 1'b1; next_resp_data = 8'hA7;
    send_req(4'h6, 1'b0, 1'b0);
    chk("bp_bundle", asynch_resp_bundle, {1'b0, 8'hA7});
    rdy_wait = 0; rsp_wait = 0; early_resp = 1'b0;

    // Back-to-back
    n0 = n_req;
    next_resp_data = 8'h31;
    send_req(4'h1, 1'b0, 1'b0);
    next_resp_data = 8'h32;
    send_req(4'h2, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("b2b_count", n_req - n0, 2);
    chk("b2b_ack_final", asynch_resp_bundle[8], 1'b0);

    // Randomized traffic
    for (int i = 0; i < 25; i++) begin
      rdy_wait = $urandom_range(0, 5);
      rsp_wait = $urandom_range(0, 5);
      early_resp = 1'($urandom_range(0, 1));
      next_resp_data = 8'($urandom);
      send_req(4'($urandom), 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rdy_wait = 0; rsp_wait = 0; early_resp = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("all_req_served", exp_req_q.size(), 0);
    chk("all_resp_returned", exp_resp_q.size(), 0);

    // Asynchronous reset while waiting for a response
    rsp_wait = 30;
    next_resp_data = 8'h99;
    src_tog = ~src_tog;
    exp_req_q.push_back(4'h9);
    asynch_req_bundle = {src_tog, 4'h9};
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (bus.resp_ready) begin
        got = 1;
        break;
      end
    end
    chk("reached_wait_resp", got, 1);
    @(posedge clk); #3;
    rstnn = 1'b0;
    asynch_req_bundle = 5'h00;
    src_tog = 1'b0;
    #1;
    chk("rst_req_valid", bus.req_valid, 1'b0);
    chk("rst_resp_ready", bus.resp_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bundle", asynch_resp_bundle, 9'h000);
    exp_req_q.delete();
    exp_resp_q.delete();
    rsp_wait = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstnn = 1'b1;
    n0 = n_req;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_no_req", n_req - n0, 0);
    chk("post_rst_bundle", asynch_resp_bundle, 9'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/asynch_toggle_handshake_receiver.md
Name: asynch_toggle_handshake_receiver

Overview:
- Destination-domain half of the two-phase, toggle-based clock-domain-crossing request/response channel.
- Receives the source side's bundle {req_toggle, req_data} from the other clock domain and synchronizes it.
- Presents each new request once to a local consumer using valid/ready.
- Captures the consumer's response and returns {ack_toggle, resp_data} to the source domain.

Parameters:
- BW_REQ_DATA, 4, width of request payload.
- BW_RESP_DATA, 8, width of response payload.

Ports:
- clk  input  1  destination-domain clock.
- rstnn  input  1  asynchronous active-low reset.
- asynch_req_bundle  input  BW_REQ_DATA+1  from the source domain; MSB is req_toggle, LSBs are req_data.
- asynch_resp_bundle  output  BW_RESP_DATA+1  to the source domain; MSB is ack_toggle, LSBs are resp_data. Driven directly from flops.
- req_valid  output  1  a request is presented to the local consumer.
- req_data  output  BW_REQ_DATA  request payload; held stable while req_valid=1.
- req_ready  input  1  consumer accepts the request.
- resp_ready  output  1  block can accept a response.
- resp_valid  input  1  consumer offers a response.
- resp_data  input  BW_RESP_DATA  response payload.
- busy  output  1  high while state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset rstnn is asynchronous and active-low.
- Input synchronization:
  - asynch_req_bundle passes through ERVP_SYNCHRONIZER (BW_DATA=BW_REQ_DATA+1, enable=1) on clk/rstnn.
  - Output is {sync_tog, sync_data}; synchronizer depth is 2 flops.
- Reset values:
  - state=IDLE, ack_tog=0, resp_data_reg=0, req_data_reg=0.
  - req_valid=0, resp_ready=0, busy=0.
  - asynch_resp_bundle=0.
- Pending request: exists when sync_tog != ack_tog.
- FSM: 5 states, registered, state output decoded from state.
  - IDLE: if pending -> SETTLE; otherwise stay.
  - SETTLE: one-cycle skew guard. Load req_data_reg <= sync_data at the end of this cycle, then -> REQ. Data is captured one cycle after the toggle change is seen, so bit skew through the synchronizer is tolerated; the source holds req_data stable until acked.
  - REQ: req_valid=1. On req_valid & req_ready -> WAIT_RESP.
  - WAIT_RESP: resp_ready=1. On resp_valid -> resp_data_reg <= resp_data, then -> ACK. resp_valid is ignored in all other states.
  - ACK: ack_tog <= ~ack_tog, then -> IDLE.
- Response ordering: resp_data_reg is updated one cycle before ack_tog flips, so the source never sees the new toggle together with stale data.
- Latency:
  - sync_tog changes in cycle k (IDLE) -> req_valid=1 in cycle k+2.
  - Response accepted in cycle m -> ack_tog flips at the end of cycle m+1.
  - Minimum local turnaround from toggle detection to ack flip: 5 cycles when req_ready and resp_valid are tied high.
- No double service: after ACK, ack_tog == sync_tog, so IDLE does not re-trigger. The source toggles again only after it observes the ack.
- Simultaneous events:
  - A req_toggle change arriving during REQ, WAIT_RESP or ACK cannot occur under protocol.
  - If it does occur, it is evaluated only on return to IDLE, as a pending mismatch.
- Output stability: req_data and asynch_resp_bundle change only on the state transitions above.
- Reset mid-operation:
  - Asynchronous return to all reset values. An outstanding req_valid drops immediately and ack_tog returns to 0.
  - Both domains must be reset together (system requirement). If only this block resets while the source toggle=1, the stale request is re-served once. This is accepted behaviour.
- Toggles wrap naturally (1-bit); there are no counters to overflow.

Test Plan:
- Reset release with asynch_req_bundle=0 -> req_valid, resp_ready and busy stay 0 for 20 cycles; asynch_resp_bundle=0.
- Drive asynch_req_bundle={1,4'hA}, req_ready=1, resp_valid=1 with resp_data=8'h5C -> req_valid pulses with req_data=4'hA, 4 cycles after the bundle changes. The resp_data field (8'h5C) is on the bundle one cycle before the MSB toggles, giving final asynch_resp_bundle={1,8'h5C}.
- Skew: change toggle to 1 one cycle before data changes 4'h0->4'h3 -> req_data=4'h3, not 4'h0.
- Backpressure: hold req_ready=0 for 10 cycles, then resp_valid=0 for 7 cycles -> req_valid and req_data stay stable; ack_tog flips only after resp_valid is accepted. resp_valid asserted early, in REQ, is ignored.
- Back-to-back: toggle 0->1 with data 1, then 1->0 with data 2 after the ack -> exactly two requests with data 1 and 2; ack_tog ends at 0.
- Assert rstnn during WAIT_RESP -> req_valid, resp_ready and asynch_resp_bundle go to 0 immediately, without waiting for a clk edge.
